// File: rtl/step_ramp_gen.sv
// Step pulse generator with trapezoidal interval ramp: accelerates from START_PERIOD
// to MIN_PERIOD, cruises, then decelerates symmetrically before the move ends.
module step_ramp_gen #(
  parameter int START_PERIOD = 2700000,
  parameter int MIN_PERIOD   = 270000,
  parameter int PERIOD_STEP  = 270000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_steps,
  input  logic        cmd_dir,
  input  logic        abort,
  output logic        rotate_pulse,
  output logic        direction,
  output logic        busy,
  output logic        done,
  output logic [15:0] steps_remaining
);

  localparam int PW = $clog2(START_PERIOD + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCEL  = 2'd1;
  localparam logic [1:0] S_CRUISE = 2'd2;
  localparam logic [1:0] S_DECEL  = 2'd3;

  logic [1:0]    state_reg, state_next;
  logic [PW-1:0] cnt_reg, cnt_next;
  logic [PW-1:0] period_reg, period_next;
  logic [15:0]   ramp_reg, ramp_next;
  logic [15:0]   steps_reg, steps_next;
  logic          pulse_reg, pulse_next;
  logic          dir_reg, dir_next;
  logic          done_reg, done_next;
  logic          busy_reg, busy_next;
  logic          ready_reg, ready_next;

  logic          fire;
  logic [31:0]   period_wide;
  logic [PW-1:0] period_dn, period_up;
  logic [15:0]   steps_dec, steps_new;

  // Saturating interval arithmetic done in 32 bits so neither direction can wrap.
  assign period_wide = 32'(period_reg);
  assign period_dn = (period_wide > 32'(MIN_PERIOD + PERIOD_STEP)) ?
                     PW'(period_wide - 32'(PERIOD_STEP)) : PW'(MIN_PERIOD);
  assign period_up = (period_wide + 32'(PERIOD_STEP) < 32'(START_PERIOD)) ?
                     PW'(period_wide + 32'(PERIOD_STEP)) : PW'(START_PERIOD);

  assign fire      = (state_reg != S_IDLE) && (cnt_reg == period_reg - PW'(1));
  assign steps_dec = steps_reg - 16'd1;

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    period_next = period_reg;
    ramp_next   = ramp_reg;
    steps_next  = steps_reg;
    pulse_next  = pulse_reg;
    dir_next    = dir_reg;
    done_next   = 1'b0;
    steps_new   = steps_dec;

    if (state_reg == S_IDLE) begin
      if (cmd_valid && ready_reg) begin
        steps_next  = cmd_steps;
        dir_next    = cmd_dir;
        cnt_next    = '0;
        ramp_next   = '0;
        period_next = PW'(START_PERIOD);
        if (cmd_steps == 16'd0) begin
          done_next = 1'b1;
        end else begin
          state_next = S_ACCEL;
        end
      end
    end else if (fire) begin
      pulse_next = ~pulse_reg;
      cnt_next   = '0;
      if (state_reg == S_ACCEL) begin
        ramp_next   = ramp_reg + 16'd1;
        period_next = period_dn;
        if (period_dn == PW'(MIN_PERIOD)) begin
          state_next = S_CRUISE;
        end
      end else if (state_reg == S_DECEL) begin
        period_next = period_up;
      end
      // A coincident abort clamps the already-decremented count, so the decel
      // check below sees the clamped value on this same edge.
      if (abort && state_reg != S_DECEL && steps_dec > ramp_next) begin
        steps_new = ramp_next;
      end
      steps_next = steps_new;
      if (state_reg != S_DECEL && steps_new <= ramp_next) begin
        state_next  = S_DECEL;
        period_next = period_up;
      end
      if (steps_new == 16'd0) begin
        state_next = S_IDLE;
        done_next  = 1'b1;
      end
    end else begin
      cnt_next = cnt_reg + PW'(1);
      if (abort && state_reg != S_DECEL) begin
        if (ramp_reg == 16'd0) begin
          state_next = S_IDLE;
          done_next  = 1'b1;
          steps_next = '0;
          cnt_next   = '0;
        end else if (steps_reg > ramp_reg) begin
          steps_next = ramp_reg;
        end
      end
    end

    busy_next  = (state_next != S_IDLE);
    ready_next = (state_next == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      period_reg <= '0;
      ramp_reg   <= '0;
      steps_reg  <= '0;
      pulse_reg  <= 1'b0;
      dir_reg    <= 1'b0;
      done_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      ready_reg  <= 1'b1;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      period_reg <= period_next;
      ramp_reg   <= ramp_next;
      steps_reg  <= steps_next;
      pulse_reg  <= pulse_next;
      dir_reg    <= dir_next;
      done_reg   <= done_next;
      busy_reg   <= busy_next;
      ready_reg  <= ready_next;
    end
  end

  assign cmd_ready       = ready_reg;
  assign rotate_pulse    = pulse_reg;
  assign direction       = dir_reg;
  assign busy            = busy_reg;
  assign done            = done_reg;
  assign steps_remaining = steps_reg;

endmodule

// File: tb/tb_step_ramp_gen.sv
// Directed bench for step_ramp_gen with START_PERIOD=10, MIN_PERIOD=4, PERIOD_STEP=2;
// toggle intervals are measured in clock edges counted from the accept edge.
module tb_step_ramp_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [15:0] cmd_steps = '0;
  logic        cmd_dir = 1'b0;
  logic        abort = 1'b0;
  logic        cmd_ready, rotate_pulse, direction, busy, done;
  logic [15:0] steps_remaining;

  int   cyc = 0;
  int   acc_cyc = 0;
  int   done_cyc = -1;
  int   checks = 0;
  int   failures = 0;
  logic last_pulse = 1'b0;
  int   tog_q[$];
  int   exp_iv[$];

  step_ramp_gen #(
    .START_PERIOD(10),
    .MIN_PERIOD  (4),
    .PERIOD_STEP (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_steps      (cmd_steps),
    .cmd_dir        (cmd_dir),
    .abort          (abort),
    .rotate_pulse   (rotate_pulse),
    .direction      (direction),
    .busy           (busy),
    .done           (done),
    .steps_remaining(steps_remaining)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One clock edge; outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rotate_pulse !== last_pulse) begin
      tog_q.push_back(cyc);
      last_pulse = rotate_pulse;
    end
    if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
  endtask

  task automatic run_move(input logic [15:0] steps, input logic dir,
                          input int abort_at, input logic spam);
    int n;
    tog_q.delete();
    done_cyc  = -1;
    cmd_valid = 1'b1;
    cmd_steps = steps;
    cmd_dir   = dir;
    tick();
    acc_cyc   = cyc;
    // Optionally keep offering a different command while busy; it must be ignored.
    cmd_valid = spam;
    cmd_steps = 16'd9;
    cmd_dir   = ~dir;
    check("dir_latch", direction, dir);
    check("busy_after_accept", busy, (steps != 16'd0));
    check("rem_after_accept", steps_remaining, steps);
    n = 0;
    while (done_cyc < 0 && n < 400) begin
      abort = (abort_at >= 0) && ((cyc + 1 - acc_cyc) == abort_at);
      tick();
      n++;
    end
    abort     = 1'b0;
    cmd_valid = 1'b0;
    if (done_cyc < 0) check("done_timeout", 0, 1);
    $display("move steps=%0d dir=%0d abort_at=%0d toggles=%0d done_at=%0d",
             steps, dir, abort_at, tog_q.size(), done_cyc - acc_cyc);
  endtask

  task automatic verify(input string name, input int exp_done, input logic dir);
    int prev;
    prev = acc_cyc;
    for (int i = 0; i < tog_q.size() && i < exp_iv.size(); i++) begin
      check($sformatf("%s_iv%0d", name, i), tog_q[i] - prev, exp_iv[i]);
      prev = tog_q[i];
    end
    check({name, "_done_at"}, done_cyc - acc_cyc, exp_done);
    check({name, "_rem_end"}, steps_remaining, 0);
    tick();
    check({name, "_toggles"}, tog_q.size(), exp_iv.size());
    check({name, "_done_1cyc"}, done, 0);
    check({name, "_busy_end"}, busy, 0);
    check({name, "_ready_end"}, cmd_ready, 1);
    check({name, "_dir_hold"}, direction, dir);
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_pulse", rotate_pulse, 0);
    check("rst_dir", direction, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rem", steps_remaining, 0);
    check("rst_ready", cmd_ready, 1);

    // Full trapezoid
    exp_iv = '{10, 8, 6, 4, 4, 6, 8, 10};
    run_move(16'd8, 1'b1, -1, 1'b0);
    verify("s8", 56, 1'b1);

    // Triangle, with a competing command held high throughout
    exp_iv = '{10, 8, 6, 8, 10};
    run_move(16'd5, 1'b0, -1, 1'b1);
    verify("s5", 42, 1'b0);

    // Zero-step command
    exp_iv = '{};
    run_move(16'd0, 1'b1, -1, 1'b0);
    verify("s0", 0, 1'b1);

    // Abort on the cruise step-fire edge 40: remaining clamps to ramp_count=3
    exp_iv = '{10, 8, 6, 4, 4, 4, 4, 6, 8, 10};
    run_move(16'd100, 1'b0, 40, 1'b0);
    verify("abort40", 64, 1'b0);

    // Abort before the first step
    exp_iv = '{};
    run_move(16'd20, 1'b1, 5, 1'b0);
    verify("abort5", 5, 1'b1);

    // Single step
    exp_iv = '{10};
    run_move(16'd1, 1'b0, -1, 1'b0);
    verify("s1", 10, 1'b0);

    // Reset in the middle of deceleration (DECEL entered at edge 32)
    tog_q.delete();
    done_cyc  = -1;
    cmd_valid = 1'b1;
    cmd_steps = 16'd8;
    cmd_dir   = 1'b1;
    tick();
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
    while (cyc - acc_cyc < 34) tick();
    check("pre_reset_toggles", tog_q.size(), 5);
    check("pre_reset_rem", steps_remaining, 3);
    reset = 1'b1;
    tick();
    check("midrst_pulse", rotate_pulse, 0);
    check("midrst_dir", direction, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_rem", steps_remaining, 0);
    check("midrst_ready", cmd_ready, 1);
    reset = 1'b0;
    done_cyc = -1;
    repeat (12) tick();
    check("midrst_no_done", done_cyc, -1);
    check("midrst_no_toggle", rotate_pulse, 0);
    $display("reset mid-decel toggles_before=5 done_after=%0d", done_cyc);

    exp_iv = '{10, 8, 10};
    run_move(16'd3, 1'b0, -1, 1'b0);
    verify("post_rst", 28, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/step_ramp_gen.md
STEP_RAMP_GEN -- requirements
Module: step_ramp_gen

Interface
REQ-001 Parameter START_PERIOD, default 2700000, clk cycles between steps at start and end of a move (100 ms at 27 MHz).
REQ-002 Parameter MIN_PERIOD, default 270000, cruise step interval in clk cycles; legal range 2 <= MIN_PERIOD <= START_PERIOD.
REQ-003 Parameter PERIOD_STEP, default 270000, interval change per step while ramping; must be >= 1.
REQ-004 clk  input  1  system clock; single clock domain.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cmd_valid  input  1  move command offered.
REQ-007 cmd_ready  output  1  block can accept a command; high only in IDLE.
REQ-008 cmd_steps  input  16  step count of the command, unsigned.
REQ-009 cmd_dir  input  1  rotation direction of the command.
REQ-010 abort  input  1  request controlled stop via deceleration.
REQ-011 rotate_pulse  output  1  toggles once per step; downstream motor driver advances on every edge.
REQ-012 direction  output  1  latched cmd_dir, stable for the whole move.
REQ-013 busy  output  1  high when state is not IDLE.
REQ-014 done  output  1  one-cycle pulse when a move completes or is dropped.
REQ-015 steps_remaining  output  16  steps not yet issued in the current move.

Function
REQ-016 States: IDLE, ACCEL, CRUISE, DECEL; all outputs registered.
REQ-017 Accept when cmd_valid && cmd_ready at an edge: latch cmd_steps into steps_remaining and cmd_dir into direction, clear interval counter and ramp_count, set period = START_PERIOD.
REQ-018 Accept with cmd_steps = 0: stay IDLE, no toggle, done high for the cycle after the accept edge.
REQ-019 Accept with cmd_steps > 0: go to ACCEL; first toggle becomes visible START_PERIOD edges after the accept edge.
REQ-020 Step fire: interval counter reaches period-1; on that edge toggle rotate_pulse, decrement steps_remaining, clear counter; consecutive toggles are exactly `period` cycles apart.
REQ-021 ACCEL step fire: ramp_count += 1; period = max(period - PERIOD_STEP, MIN_PERIOD); go to CRUISE when the new period equals MIN_PERIOD.
REQ-022 Decel check after every ACCEL/CRUISE step fire, overriding REQ-021: if new steps_remaining <= ramp_count, go to DECEL with period = min(last interval + PERIOD_STEP, START_PERIOD).
REQ-023 DECEL step fire: period = min(period + PERIOD_STEP, START_PERIOD).
REQ-024 Any step fire that takes steps_remaining to 0: go to IDLE, with done high for one cycle on that same edge; cmd_ready high from the next cycle.
REQ-025 PERIOD_STEP arithmetic is saturating: no underflow below MIN_PERIOD, no overflow above START_PERIOD.
REQ-026 abort in ACCEL/CRUISE: steps_remaining = min(steps_remaining, ramp_count), and the next step fire enters DECEL per REQ-022.
REQ-027 abort with ramp_count = 0 (before first step): go to IDLE next edge, done pulse, no toggle.
REQ-028 abort on the same edge as a step fire: apply the step fire first, then REQ-026 to the decremented count.
REQ-029 abort in IDLE or DECEL is ignored.
REQ-030 cmd_valid while busy is ignored; the command is not queued.

Reset
REQ-031 On reset: state IDLE, rotate_pulse 0, direction 0, busy 0, done 0, steps_remaining 0, internal counters 0, cmd_ready 1 from the first cycle after reset deasserts.
REQ-032 Reset mid-move aborts immediately, with no done pulse and no further toggles.

Verification (START_PERIOD=10, MIN_PERIOD=4, PERIOD_STEP=2)
REQ-033 cmd_steps=8 -> toggle intervals 10,8,6,4,4,6,8,10; done on the 8th toggle edge; steps_remaining ends at 0.
REQ-034 cmd_steps=5 -> intervals 10,8,6,8,10; never enters CRUISE.
REQ-035 cmd_steps=0 -> no toggle; done for 1 cycle after accept; busy stays 0.
REQ-036 cmd_steps=100, abort asserted at cycle 40 (in CRUISE, ramp_count=3) -> 3 more toggles at intervals 6,8,10 after the next step fire, then done; total steps < 100.
REQ-037 abort 5 cycles after accept -> no toggle; done next cycle; IDLE.
REQ-038 Reset asserted mid-DECEL -> all outputs at reset values next cycle; no done pulse; new command accepted afterwards with first interval 10.
